// File: rtl/mul_sequencer_pkg.sv
// Shared types for the iterative EX-stage multiplier.
// ALU control encodings and sequencer state encoding.
package mul_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: folds BITS_PER_CYCLE multiplier
// bits into the accumulator, modulo 2^WIDTH.
module mul_step
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  output logic [WIDTH-1:0]          acc_next
);

  always_comb begin
    acc_next = acc;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (bits[b]) begin
        acc_next = acc_next + (mcand << b);
      end
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier controller beside the EX ALU.
// Stalls the pipeline while iterating, then pulses done_o once.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mul_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .bits     (mplier[BITS_PER_CYCLE-1:0]),
    .acc_next (acc_next)
  );

  // Must rise in the start cycle so the multiply stays held in EX.
  assign stall_o = (state == IDLE && start_i && !flush_i)
                 || (state == BUSY);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      done_o <= 1'b0;
      data_o <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            data_o <= acc_next;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer at 1 and 4 bits per cycle.
// Both instances share data/flush/reset; each has its own start.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start1;
  logic        start4;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        stall1, done1;
  logic [31:0] q1;
  logic        stall4, done4;
  logic [31:0] q4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start1),
    .data1_i (d1),
    .data2_i (d2),
    .flush_i (flush),
    .stall_o (stall1),
    .done_o  (done1),
    .data_o  (q1)
  );

  mul_sequencer #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start4),
    .data1_i (d1),
    .data2_i (d2),
    .flush_i (flush),
    .stall_o (stall4),
    .done_o  (done4),
    .data_o  (q4)
  );

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    start1 = 1'b0; start4 = 1'b0;
    d1 = 32'h0; d2 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", stall1);
    end
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done1);
    end
    checks++;
    if (q1 !== 32'h0 || q4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 0", q1, q4);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete multiply on the chosen instance, checking latency,
  // stall length, stall low at done, result and single-cycle pulse.
  task automatic run_op(input bit sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int n, input bit zap, input string nm);
    int c;
    int stalls;
    int done_at;
    logic st, dn, st_at_done;
    logic [31:0] q;
    stalls = 0; done_at = -1; st_at_done = 1'bx; q = 'x;
    @(negedge clk);
    d1 = a; d2 = b;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    for (c = 0; c < 200 && done_at < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c == 1) begin
          start1 = 1'b0; start4 = 1'b0;
          if (zap) begin d1 = 32'h0; d2 = 32'h0; end
        end
      end
      #1;
      st = sel ? stall4 : stall1;
      dn = sel ? done4 : done1;
      if (st === 1'b1) stalls++;
      if (dn === 1'b1) begin
        done_at = c;
        st_at_done = st;
        q = sel ? q4 : q1;
      end
    end
    checks++;
    if (done_at != n + 1) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", nm, done_at, n + 1);
    end
    checks++;
    if (stalls != n + 1) begin
      errors++;
      $display("FAIL %s_stall_len got %0d want %0d", nm, stalls, n + 1);
    end
    checks++;
    if (st_at_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall_at_done got %b want 0", nm, st_at_done);
    end
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s_data got %h want %h", nm, q, exp);
    end
    @(negedge clk);
    #1;
    dn = sel ? done4 : done1;
    checks++;
    if (dn !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse got %b want 0", nm, dn);
    end
  endtask

  task automatic test_basic();
    run_op(1'b0, 32'd3, 32'd5, 32'd15, 32, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32, 1'b0, "wrap_ff");
    run_op(1'b0, 32'h80000000, 32'd2, 32'h00000000, 32, 1'b0, "wrap_msb");
    run_op(1'b0, 32'h12345678, 32'h10, 32'h23456780, 32, 1'b0, "wrap_shift");
  endtask

  task automatic test_operand_change();
    run_op(1'b0, 32'd7, 32'd6, 32'd42, 32, 1'b1, "opchange");
  endtask

  // Abort 9*9 in cycle 10 via flush (kill=0) or reset (kill=1).
  task automatic test_abort(input bit kill, input logic [31:0] keep,
                            input string nm);
    int seen;
    @(negedge clk);
    d1 = 32'd9; d2 = 32'd9; start1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start1 = 1'b0;
    end
    if (kill) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (stall1 !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall got %b want 0", nm, stall1);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done1 === 1'b1) seen++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s_no_done got %0d pulses want 0", nm, seen);
    end
    checks++;
    if (q1 !== keep) begin
      errors++;
      $display("FAIL %s_data got %h want %h", nm, q1, keep);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int first;
    int second;
    logic [31:0] r1, r2;
    first = -1; second = -1; r1 = 'x; r2 = 'x;
    @(negedge clk);
    d1 = 32'd2; d2 = 32'd3; start1 = 1'b1;
    for (c = 0; c < 200 && second < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) start1 = 1'b0;
      #1;
      if (done1 === 1'b1) begin
        if (first < 0) begin
          first = c; r1 = q1;
          d1 = 32'd4; d2 = 32'd5; start1 = 1'b1;
        end else begin
          second = c; r2 = q1;
        end
      end else if (first >= 0 && c == first + 1) begin
        checks++;
        if (stall1 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart_stall got %b want 1", stall1);
        end
        @(negedge clk);
        start1 = 1'b0;
        c++;
      end
    end
    checks++;
    if (second - first != 34 || first < 0) begin
      errors++;
      $display("FAIL b2b_gap got %0d want 34", second - first);
    end
    checks++;
    if (r1 !== 32'd6) begin
      errors++;
      $display("FAIL b2b_first got %h want %h", r1, 32'd6);
    end
    checks++;
    if (r2 !== 32'd20) begin
      errors++;
      $display("FAIL b2b_second got %h want %h", r2, 32'd20);
    end
  endtask

  task automatic test_flush_start();
    int seen;
    @(negedge clk);
    d1 = 32'd11; d2 = 32'd13; start1 = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_stall got %b want 0", stall1);
    end
    @(negedge clk);
    start1 = 1'b0; flush = 1'b0;
    #1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done1 === 1'b1 || stall1 === 1'b1) seen++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_start_idle got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_sweep();
    run_op(1'b1, 32'hDEADBEEF, 32'h0000CAFE, 32'h090C0722, 8, 1'b0, "bpc4_dead");
    run_op(1'b1, 32'h12345678, 32'h10, 32'h23456780, 8, 1'b0, "bpc4_shift");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_operand_change();
    test_abort(1'b0, 32'd42, "flush_mid");
    test_abort(1'b1, 32'd0, "reset_mid");
    test_back_to_back();
    test_flush_start();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
